spireg_arbiter: RTL and testbench

- Owns the register bank behind the SPI register slave and shares it between two requesters.
- Host side: SPI write strobes plus fast commands. Engine side: the RSA core, using a req/gnt handshake.
- SPI writes land in a one-entry pending buffer. Buffered SPI writes and engine accesses are round-robin arbitrated, one commit per clk.
- Also generates the 8-bit status byte that the SPI slave returns on every command.

---
 rtl/spireg_arbiter_if.sv | 40 ++++
 rtl/spireg_arbiter.sv | 144 ++++++++++++++
 tb/tb_spireg_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/spireg_arbiter_if.sv
// ============================================================================
// Module  : spireg_arbiter_if
// Purpose : Host (SPI / fast command) and engine (req/gnt) bus of the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface spireg_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int REG_W  = 8
);
    logic [ADDR_W-1:0] spi_addr;
    logic [REG_W-1:0]  spi_wdata;
    logic              spi_wvld;
    logic [REG_W-1:0]  spi_rdata;
    logic [5:0]        fastcmd;
    logic              fastcmd_vld;
    logic [7:0]        status;
    logic              eng_req;
    logic              eng_we;
    logic [ADDR_W-1:0] eng_addr;
    logic [REG_W-1:0]  eng_wdata;
    logic              eng_gnt;
    logic [REG_W-1:0]  eng_rdata;
    logic              eng_rvld;

    modport master (
        output spi_addr, spi_wdata, spi_wvld, fastcmd, fastcmd_vld,
               eng_req, eng_we, eng_addr, eng_wdata,
        input  spi_rdata, status, eng_gnt, eng_rdata, eng_rvld
    );

    modport slave (
        input  spi_addr, spi_wdata, spi_wvld, fastcmd, fastcmd_vld,
               eng_req, eng_we, eng_addr, eng_wdata,
        output spi_rdata, status, eng_gnt, eng_rdata, eng_rvld
    );
endinterface

`default_nettype wire

// File: rtl/spireg_arbiter.sv
// ============================================================================
// Module  : spireg_arbiter
// Purpose : Register bank shared between SPI host writes and the RSA engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spireg_arbiter #(
    parameter int ADDR_W = 3,
    parameter int REG_W  = 8
) (
    input  wire logic         clk,
    input  wire logic         nrst,
    spireg_arbiter_if.slave   bus
);

    localparam int          DEPTH      = 2 ** ADDR_W;
    localparam logic [31:0] c_fc_limit = 32'(2 * REG_W);

    typedef enum logic [0:0] {
        RR_SPI = 1'b0,
        RR_ENG = 1'b1
    } rr_t;

    rr_t               r_rr_last;
    logic              r_pend_vld;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [REG_W-1:0]  r_pend_data;
    logic              r_ovf;
    logic              r_eng_gnt;
    logic              r_rd_pend;
    logic [REG_W-1:0]  r_rd_stage;
    logic [REG_W-1:0]  r_eng_rdata;
    logic              r_eng_rvld;

    logic [REG_W-1:0]  w_mem [DEPTH];
    logic              w_both;
    logic              w_serve_spi;
    logic              w_serve_eng;
    logic              w_eng_wr;
    logic              w_eng_rd;
    logic              w_fc_ok;
    logic [REG_W-1:0]  w_fc_mask;
    logic [REG_W-1:0]  w_reg0_base;
    logic [REG_W-1:0]  w_reg0_next;

    // Round-robin only matters under contention; a lone candidate always wins.
    assign w_both      = r_pend_vld & bus.eng_req;
    assign w_serve_spi = r_pend_vld  & (~bus.eng_req | (r_rr_last == RR_ENG));
    assign w_serve_eng = bus.eng_req & (~r_pend_vld  | (r_rr_last == RR_SPI));
    assign w_eng_wr    = w_serve_eng & bus.eng_we & (bus.eng_addr != '0);
    assign w_eng_rd    = w_serve_eng & ~bus.eng_we;

    assign w_fc_ok     = bus.fastcmd_vld & ({26'd0, bus.fastcmd} < c_fc_limit);
    assign w_fc_mask   = REG_W'(1) << bus.fastcmd[5:1];

    // Reg 0: SPI commit lays down the full word, the fast command bit wins over it.
    assign w_reg0_base = (w_serve_spi && (r_pend_addr == '0)) ? r_pend_data : w_mem[0];
    assign w_reg0_next = w_fc_ok
                       ? ((w_reg0_base & ~w_fc_mask) | (w_fc_mask & {REG_W{bus.fastcmd[0]}}))
                       : w_reg0_base;

    for (genvar a = 0; a < DEPTH; a++) begin : g_mem
        logic [REG_W-1:0] r_word;

        if (a == 0) begin : g_ctrl
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    r_word <= '0;
                end else begin
                    r_word <= w_reg0_next;
                end
            end
        end else begin : g_data
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    r_word <= '0;
                end else if (w_serve_spi && (r_pend_addr == ADDR_W'(a))) begin
                    r_word <= r_pend_data;
                end else if (w_eng_wr && (bus.eng_addr == ADDR_W'(a))) begin
                    r_word <= bus.eng_wdata;
                end
            end
        end

        assign w_mem[a] = r_word;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_ovf       <= 1'b0;
        end else if (bus.spi_wvld) begin
            r_pend_vld  <= 1'b1;
            r_pend_addr <= bus.spi_addr;
            r_pend_data <= bus.spi_wdata;
            if (r_pend_vld && !w_serve_spi) begin
                r_ovf <= 1'b1;
            end
        end else if (w_serve_spi) begin
            r_pend_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rr_last <= RR_ENG;
        end else if (w_both) begin
            r_rr_last <= w_serve_spi ? RR_SPI : RR_ENG;
        end
    end

    // Read data is staged so it lines up with eng_rvld one cycle after the grant.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_eng_gnt   <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_stage  <= '0;
            r_eng_rdata <= '0;
            r_eng_rvld  <= 1'b0;
        end else begin
            r_eng_gnt  <= w_serve_eng;
            r_rd_pend  <= w_eng_rd;
            r_eng_rvld <= r_rd_pend;
            if (w_eng_rd) begin
                r_rd_stage <= w_mem[bus.eng_addr];
            end
            if (r_rd_pend) begin
                r_eng_rdata <= r_rd_stage;
            end
        end
    end

    assign bus.spi_rdata = w_mem[bus.spi_addr];
    assign bus.status    = {r_ovf, bus.eng_req & ~r_eng_gnt, w_mem[0][5:0]};
    assign bus.eng_gnt   = r_eng_gnt;
    assign bus.eng_rdata = r_eng_rdata;
    assign bus.eng_rvld  = r_eng_rvld;

endmodule

`default_nettype wire

// File: tb/tb_spireg_arbiter.sv
// ============================================================================
// Module  : tb_spireg_arbiter
// Purpose : Directed self-checking bench for spireg_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spireg_arbiter;

    logic clk;
    logic nrst;
    int   n_pass;
    int   n_total;

    spireg_arbiter_if #(.ADDR_W(3), .REG_W(8)) bus ();

    spireg_arbiter #(.ADDR_W(3), .REG_W(8)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        nrst    = 1'b0;
        bus.spi_addr    = '0;
        bus.spi_wdata   = '0;
        bus.spi_wvld    = 1'b0;
        bus.fastcmd     = '0;
        bus.fastcmd_vld = 1'b0;
        bus.eng_req     = 1'b0;
        bus.eng_we      = 1'b0;
        bus.eng_addr    = '0;
        bus.eng_wdata   = '0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        #1;
        check("rst_status", bus.status, 64'h00);
        check("rst_gnt", bus.eng_gnt, 64'h0);
        check("rst_rvld", bus.eng_rvld, 64'h0);
        for (int a = 0; a < 8; a++) begin
            bus.spi_addr = 3'(a);
            #1;
            check($sformatf("rst_rdata%0d", a), bus.spi_rdata, 64'h00);
        end

        // SPI write, no engine traffic
        bus.spi_addr = 3'd3; bus.spi_wdata = 8'hA5; bus.spi_wvld = 1'b1;
        tick();
        bus.spi_wvld = 1'b0; #1;
        check("a_pending_hidden", bus.spi_rdata, 64'h00);
        check("a_status", bus.status, 64'h00);
        tick(); #1;
        check("a_visible", bus.spi_rdata, 64'hA5);

        // Engine read contending with a pending SPI write, SPI wins first
        bus.spi_wdata = 8'h5A; bus.spi_wvld = 1'b1;
        tick();
        bus.spi_wvld = 1'b0;
        bus.eng_req = 1'b1; bus.eng_we = 1'b0; bus.eng_addr = 3'd3; #1;
        check("b_eng_pend", bus.status, 64'h40);
        check("b_old_value", bus.spi_rdata, 64'hA5);
        tick(); #1;
        check("b_spi_first", bus.eng_gnt, 64'h0);
        check("b_spi_commit", bus.spi_rdata, 64'h5A);
        tick(); #1;
        check("b_gnt", bus.eng_gnt, 64'h1);
        check("b_rvld_early", bus.eng_rvld, 64'h0);
        bus.eng_req = 1'b0;
        tick(); #1;
        check("b_gnt_drop", bus.eng_gnt, 64'h0);
        check("b_rvld", bus.eng_rvld, 64'h1);
        check("b_rdata", bus.eng_rdata, 64'h5A);
        tick(); #1;
        check("b_rvld_pulse", bus.eng_rvld, 64'h0);

        // Engine writes: address 0 dropped, address 5 lands
        bus.eng_req = 1'b1; bus.eng_we = 1'b1; bus.eng_addr = 3'd0; bus.eng_wdata = 8'h3C;
        tick(); #1;
        check("c_gnt0", bus.eng_gnt, 64'h1);
        bus.eng_req = 1'b0; bus.spi_addr = 3'd0; #1;
        check("c_reg0_kept", bus.spi_rdata, 64'h00);
        tick(); #1;
        check("c_gnt0_drop", bus.eng_gnt, 64'h0);
        check("c_no_rvld", bus.eng_rvld, 64'h0);
        bus.eng_req = 1'b1; bus.eng_addr = 3'd5;
        tick(); #1;
        check("c_gnt5", bus.eng_gnt, 64'h1);
        bus.eng_req = 1'b0;
        tick();
        bus.spi_addr = 3'd5; #1;
        check("c_reg5", bus.spi_rdata, 64'h3C);

        // Fast commands
        bus.fastcmd = 6'd1; bus.fastcmd_vld = 1'b1;
        tick();
        bus.fastcmd = 6'd3;
        tick();
        bus.fastcmd = 6'd5;
        tick();
        bus.fastcmd_vld = 1'b0; bus.spi_addr = 3'd0; #1;
        check("d_reg0", bus.spi_rdata, 64'h07);
        check("d_status", bus.status, 64'h07);
        bus.spi_wdata = 8'hFF; bus.spi_wvld = 1'b1;
        tick();
        bus.spi_wvld = 1'b0; bus.fastcmd = 6'd2; bus.fastcmd_vld = 1'b1;
        tick();
        bus.fastcmd_vld = 1'b0; #1;
        check("d_commit_fc", bus.spi_rdata, 64'hFD);
        check("d_status_fd", bus.status, 64'h3D);
        bus.fastcmd = 6'd20; bus.fastcmd_vld = 1'b1;
        tick();
        bus.fastcmd = 6'd16;
        tick();
        bus.fastcmd_vld = 1'b0; #1;
        check("d_fc_ignored", bus.spi_rdata, 64'hFD);
        bus.fastcmd = 6'd14; bus.fastcmd_vld = 1'b1;
        tick();
        bus.fastcmd_vld = 1'b0; #1;
        check("d_fc_top_bit", bus.spi_rdata, 64'h7D);

        // Continuous engine reads with back-to-back SPI strobes
        bus.eng_req = 1'b1; bus.eng_we = 1'b0; bus.eng_addr = 3'd5;
        bus.spi_addr = 3'd6; bus.spi_wdata = 8'h11; bus.spi_wvld = 1'b1;
        tick();
        bus.spi_wdata = 8'h22; #1;
        check("e_gnt1", bus.eng_gnt, 64'h1);
        tick();
        bus.spi_wvld = 1'b0; #1;
        check("e_gnt2", bus.eng_gnt, 64'h1);
        check("e_ovf_status", bus.status, 64'hBD);
        tick(); #1;
        check("e_spi_turn", bus.eng_gnt, 64'h0);
        check("e_wait_status", bus.status, 64'hFD);
        check("e_overwrite", bus.spi_rdata, 64'h22);
        check("e_rvld", bus.eng_rvld, 64'h1);
        check("e_rdata", bus.eng_rdata, 64'h3C);
        tick(); #1;
        check("e_gnt4", bus.eng_gnt, 64'h1);
        bus.spi_addr = 3'd7; bus.spi_wdata = 8'h33; bus.spi_wvld = 1'b1;
        tick();
        bus.spi_wvld = 1'b0; #1;
        check("e_gnt5", bus.eng_gnt, 64'h1);
        tick(); #1;
        check("e_eng_turn", bus.eng_gnt, 64'h1);
        check("e_reg7_pending", bus.spi_rdata, 64'h00);
        tick(); #1;
        check("e_spi_turn2", bus.eng_gnt, 64'h0);
        check("e_reg7", bus.spi_rdata, 64'h33);
        bus.eng_req = 1'b0;
        tick();

        // Reset in the middle of traffic
        bus.spi_addr = 3'd1; bus.spi_wdata = 8'h44; bus.spi_wvld = 1'b1;
        bus.eng_req = 1'b1; bus.eng_we = 1'b0; bus.eng_addr = 3'd5;
        tick();
        bus.spi_wvld = 1'b0; #1;
        check("f_gnt", bus.eng_gnt, 64'h1);
        nrst = 1'b0; bus.eng_req = 1'b0; #1;
        check("f_gnt_cleared", bus.eng_gnt, 64'h0);
        check("f_status", bus.status, 64'h00);
        tick();
        nrst = 1'b1;
        tick(); #1;
        check("f_pend_dropped", bus.spi_rdata, 64'h00);
        check("f_rvld", bus.eng_rvld, 64'h0);
        check("f_gnt_idle", bus.eng_gnt, 64'h0);
        bus.spi_addr = 3'd5; #1;
        check("f_reg5", bus.spi_rdata, 64'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
